// File: rtl/bus_resolver_keeper.sv
// Multi-driver bus resolver (tri / wired-AND / wired-OR) with a bounded charge keeper.
// Optional strict single-owner checking and multi_drive output: BUS_RESOLVER_ONEHOT_CHECK_EN.
`timescale 1ns/1ps

module bus_resolver_keeper #(
    parameter int unsigned      N_DRV       = 4,
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      MODE        = 0,
    parameter int unsigned      KEEP_CYCLES = 3,
    parameter logic [WIDTH-1:0] FLOAT_VAL   = '0,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DRV-1:0]         drv_en,
    input  logic [N_DRV*WIDTH-1:0]   drv_data,
    input  logic                     conflict_clr,
    output logic [WIDTH-1:0]         bus_data,
    output logic                     bus_driven,
    output logic                     bus_float,
    output logic                     conflict,
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
    output logic                     multi_drive,
`endif
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int unsigned KEEP_W   = (KEEP_CYCLES < 1) ? 1 : $clog2(KEEP_CYCLES + 1);
    localparam logic [KEEP_W-1:0] KEEP_MAX = KEEP_W'(KEEP_CYCLES);
    // Unknown mode encodings fall back to tri resolution.
    localparam int unsigned EFF_MODE = (MODE == 1 || MODE == 2) ? MODE : 0;

    logic [WIDTH-1:0]  drv_word;
    logic [WIDTH-1:0]  first_data;
    logic [WIDTH-1:0]  and_data;
    logic [WIDTH-1:0]  or_data;
    logic [WIDTH-1:0]  resolved;
    logic              found;
    logic              multi;
    logic              disagree;
    logic              tri_conflict;

    logic [KEEP_W-1:0] keep_cnt;
    logic [KEEP_W-1:0] keep_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic              driven_nxt;
    logic              float_nxt;
    logic              conflict_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Scan drivers: lowest-index owner, wired reductions, agreement and multi-drive.
    always_comb begin
        drv_word   = '0;
        first_data = '0;
        and_data   = '1;
        or_data    = '0;
        found      = 1'b0;
        multi      = 1'b0;
        disagree   = 1'b0;
        for (int unsigned i = 0; i < N_DRV; i++) begin
            drv_word = drv_data[i*WIDTH +: WIDTH];
            if (drv_en[i]) begin
                and_data = and_data & drv_word;
                or_data  = or_data | drv_word;
                if (!found) begin
                    first_data = drv_word;
                    found      = 1'b1;
                end else begin
                    multi = 1'b1;
                    if (drv_word != first_data) begin
                        disagree = 1'b1;
                    end
                end
            end
        end
    end

    // Mode-dependent resolved value and conflict condition.
    always_comb begin
        if (EFF_MODE == 1) begin
            resolved = and_data;
        end else if (EFF_MODE == 2) begin
            resolved = or_data;
        end else begin
            resolved = first_data;
        end
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
        tri_conflict = (EFF_MODE == 0) && (disagree || multi);
`else
        tri_conflict = (EFF_MODE == 0) && disagree;
`endif
    end

    // Keeper: hold last value for KEEP_CYCLES undriven cycles, then float.
    always_comb begin
        data_nxt     = bus_data;
        driven_nxt   = 1'b0;
        float_nxt    = bus_float;
        conflict_nxt = 1'b0;
        keep_nxt     = keep_cnt;
        if (found) begin
            data_nxt     = resolved;
            driven_nxt   = 1'b1;
            float_nxt    = 1'b0;
            conflict_nxt = tri_conflict;
            keep_nxt     = '0;
        end else if (keep_cnt != KEEP_MAX) begin
            keep_nxt = keep_cnt + KEEP_W'(1);
        end else begin
            data_nxt  = FLOAT_VAL;
            float_nxt = 1'b1;
        end
    end

    // Saturating conflict counter; clear has priority over a same-cycle conflict.
    always_comb begin
        cnt_nxt = conflict_cnt;
        if (conflict_clr) begin
            cnt_nxt = '0;
        end else if (conflict_nxt && (conflict_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = conflict_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_data     <= FLOAT_VAL;
            bus_driven   <= 1'b0;
            bus_float    <= 1'b1;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
            keep_cnt     <= '0;
        end else begin
            bus_data     <= data_nxt;
            bus_driven   <= driven_nxt;
            bus_float    <= float_nxt;
            conflict     <= conflict_nxt;
            conflict_cnt <= cnt_nxt;
            keep_cnt     <= keep_nxt;
        end
    end

`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            multi_drive <= 1'b0;
        end else begin
            multi_drive <= multi;
        end
    end
`endif

endmodule

// File: tb/tb_bus_resolver_keeper.sv
// Scoreboard bench: four resolver configurations share stimulus and are checked
// against a list-based reference model of the resolution and keeper rules.
`timescale 1ns/1ps

module tb_bus_resolver_keeper;

    localparam int unsigned NI = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       drv;
        logic       flt;
        logic       conf;
        logic [7:0] cnt;
        logic       md;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conflict_clr = 1'b0;
    logic [3:0]  drv_en = '0;
    logic [31:0] drv_data = '0;

    always #5 clk = ~clk;

    logic [7:0] bd [NI];
    logic       bdrv [NI];
    logic       bflt [NI];
    logic       bcf [NI];
    logic       md [NI];
    logic [1:0] cnt_tri;
    logic [7:0] cnt_and, cnt_or, cnt_k0;

    bus_resolver_keeper #(.N_DRV(4), .WIDTH(8), .MODE(0), .KEEP_CYCLES(3), .FLOAT_VAL(8'h00), .CNT_W(2)) u_tri (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .conflict_clr(conflict_clr),
        .bus_data(bd[0]), .bus_driven(bdrv[0]), .bus_float(bflt[0]), .conflict(bcf[0]),
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
        .multi_drive(md[0]),
`endif
        .conflict_cnt(cnt_tri));

    bus_resolver_keeper #(.N_DRV(4), .WIDTH(8), .MODE(1), .KEEP_CYCLES(3), .FLOAT_VAL(8'h00), .CNT_W(8)) u_and (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .conflict_clr(conflict_clr),
        .bus_data(bd[1]), .bus_driven(bdrv[1]), .bus_float(bflt[1]), .conflict(bcf[1]),
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
        .multi_drive(md[1]),
`endif
        .conflict_cnt(cnt_and));

    bus_resolver_keeper #(.N_DRV(4), .WIDTH(8), .MODE(2), .KEEP_CYCLES(3), .FLOAT_VAL(8'h00), .CNT_W(8)) u_or (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .conflict_clr(conflict_clr),
        .bus_data(bd[2]), .bus_driven(bdrv[2]), .bus_float(bflt[2]), .conflict(bcf[2]),
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
        .multi_drive(md[2]),
`endif
        .conflict_cnt(cnt_or));

    // Mode 3 must behave as tri; no keeper and a non-zero float value.
    bus_resolver_keeper #(.N_DRV(4), .WIDTH(8), .MODE(3), .KEEP_CYCLES(0), .FLOAT_VAL(8'hE7), .CNT_W(8)) u_k0 (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .conflict_clr(conflict_clr),
        .bus_data(bd[3]), .bus_driven(bdrv[3]), .bus_float(bflt[3]), .conflict(bcf[3]),
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
        .multi_drive(md[3]),
`endif
        .conflict_cnt(cnt_k0));

`ifndef BUS_RESOLVER_ONEHOT_CHECK_EN
    initial for (int k = 0; k < NI; k++) md[k] = 1'b0;
`endif

    logic [7:0] act_cnt [NI];
    assign act_cnt[0] = 8'(cnt_tri);
    assign act_cnt[1] = cnt_and;
    assign act_cnt[2] = cnt_or;
    assign act_cnt[3] = cnt_k0;

    // Reference configuration and state.
    int unsigned m_mode  [NI] = '{0, 1, 2, 0};
    int unsigned m_keep  [NI] = '{3, 3, 3, 0};
    logic [7:0]  m_float [NI] = '{8'h00, 8'h00, 8'h00, 8'hE7};
    int unsigned m_cmax  [NI] = '{3, 255, 255, 255};

    logic [7:0]  s_data [NI];
    logic        s_flt  [NI];
    int unsigned s_hold [NI];
    int unsigned s_cnt  [NI];

    exp_t [NI-1:0] sb_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_step(input bit r, input logic [3:0] en, input logic [31:0] dd, input bit clr);
        exp_t [NI-1:0] ev;
        logic [7:0] vals [$];
        logic [7:0] v;
        bit conf;
        for (int i = 0; i < 4; i++) if (en[i]) vals.push_back(dd[i*8 +: 8]);
        for (int k = 0; k < NI; k++) begin
            conf = 1'b0;
            if (r) begin
                s_data[k] = m_float[k];
                s_flt[k]  = 1'b1;
                s_hold[k] = 0;
                s_cnt[k]  = 0;
            end else if (vals.size() > 0) begin
                if (m_mode[k] == 1) begin
                    v = 8'hFF;
                    foreach (vals[j]) v = v & vals[j];
                end else if (m_mode[k] == 2) begin
                    v = 8'h00;
                    foreach (vals[j]) v = v | vals[j];
                end else begin
                    v = vals[0];
                    foreach (vals[j]) if (vals[j] != vals[0]) conf = 1'b1;
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
                    if (vals.size() > 1) conf = 1'b1;
`endif
                end
                s_data[k] = v;
                s_flt[k]  = 1'b0;
                s_hold[k] = 0;
            end else if (s_hold[k] < m_keep[k]) begin
                s_hold[k]++;
            end else begin
                s_data[k] = m_float[k];
                s_flt[k]  = 1'b1;
            end
            if (!r) begin
                if (clr) s_cnt[k] = 0;
                else if (conf && s_cnt[k] < m_cmax[k]) s_cnt[k]++;
            end
            ev[k].data = s_data[k];
            ev[k].drv  = !r && (vals.size() > 0);
            ev[k].flt  = s_flt[k];
            ev[k].conf = conf;
            ev[k].cnt  = 8'(s_cnt[k]);
            ev[k].md   = !r && (vals.size() > 1);
        end
        sb_q.push_back(ev);
    endtask

    task automatic cycle(input bit r, input logic [3:0] en, input logic [31:0] dd, input bit clr);
        @(negedge clk);
        rst          = r;
        drv_en       = en;
        drv_data     = dd;
        conflict_clr = clr;
        model_step(r, en, dd, clr);
    endtask

    task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t got %h expected %h", nm, k, $time, got, expv);
        end
    endtask

    // Monitor: one expected entry per registered output cycle.
    initial begin
        exp_t [NI-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    chk("bus_data",     k, bd[k],           e[k].data);
                    chk("bus_driven",   k, 8'(bdrv[k]),     8'(e[k].drv));
                    chk("bus_float",    k, 8'(bflt[k]),     8'(e[k].flt));
                    chk("conflict",     k, 8'(bcf[k]),      8'(e[k].conf));
                    chk("conflict_cnt", k, act_cnt[k],      e[k].cnt);
`ifdef BUS_RESOLVER_ONEHOT_CHECK_EN
                    chk("multi_drive",  k, 8'(md[k]),       8'(e[k].md));
`endif
                end
            end
        end
    end

    initial begin
        int unsigned idle_run = 0;
        logic [3:0]  en;
        logic [31:0] dd;
        logic [7:0]  base;

        cycle(1, 4'b0000, 32'h0, 0);
        cycle(1, 4'b0000, 32'h0, 0);
        // Tri ownership, disagreement and agreement.
        cycle(0, 4'b0001, 32'h000000A5, 0);
        cycle(0, 4'b0011, 32'h00005AA5, 0);
        cycle(0, 4'b0011, 32'h0000A5A5, 0);
        // Wired reductions.
        cycle(0, 4'b0110, 32'h003CF000, 0);
        // Keeper hold, expiry and re-drive.
        cycle(0, 4'b0001, 32'h00000077, 0);
        repeat (5) cycle(0, 4'b0000, 32'h0, 0);
        cycle(0, 4'b0001, 32'h00000011, 0);
        // Counter saturation and clear-wins.
        repeat (5) cycle(0, 4'b0011, 32'h00000201, 0);
        cycle(0, 4'b0011, 32'h00000201, 1);
        // Reset in the middle of a hold window.
        cycle(0, 4'b0001, 32'h00000077, 0);
        cycle(0, 4'b0000, 32'h0, 0);
        cycle(1, 4'b0000, 32'h0, 0);
        cycle(0, 4'b0000, 32'h0, 0);
        cycle(0, 4'b0000, 32'h0, 0);

        for (int n = 0; n < 2000; n++) begin
            if (idle_run > 0) begin
                en = 4'b0000;
                idle_run--;
            end else if ($urandom_range(0, 9) < 2) begin
                en = 4'b0000;
                idle_run = $urandom_range(0, 6);
            end else begin
                en = 4'($urandom_range(1, 15));
            end
            base = 8'($urandom);
            for (int i = 0; i < 4; i++) dd[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? base : 8'($urandom);
            cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, en, dd,
                  ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
